// File: rtl/eq_pkg.sv
// Shared types and constants for the biquad coefficient scheduler.
package eq_pkg;

    localparam int COEF_W = 18;
    localparam logic signed [COEF_W-1:0] COEF_ONE = 18'h10000;

    localparam logic [2:0] SEL_B0 = 3'd0;
    localparam logic [2:0] SEL_B1 = 3'd1;
    localparam logic [2:0] SEL_B2 = 3'd2;
    localparam logic [2:0] SEL_A1 = 3'd3;
    localparam logic [2:0] SEL_A2 = 3'd4;

    typedef struct packed {
        logic signed [COEF_W-1:0] b0;
        logic signed [COEF_W-1:0] b1;
        logic signed [COEF_W-1:0] b2;
        logic signed [COEF_W-1:0] a1;
        logic signed [COEF_W-1:0] a2;
    } coef_set_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RELEASE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/eq_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after last+1, wrapping.
module eq_rr_picker #(
    parameter  int NUM_BIQUADS = 8,
    localparam int IDX_W       = $clog2(NUM_BIQUADS)
) (
    input  logic [NUM_BIQUADS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic                   grant_valid,
    output logic [IDX_W-1:0]       grant_idx
);

    int k;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        k           = 0;
        // Offset 1 is searched first, so the band just served has lowest priority.
        for (int i = 1; i <= NUM_BIQUADS; i++) begin
            k = (int'(last) + i) % NUM_BIQUADS;
            if (!grant_valid && req[IDX_W'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/biquad_coef_scheduler.sv
// Staging bank plus round-robin loader feeding audio_controller one band at a time.
// Optional handshake watchdog is enabled by defining EQ_LOAD_TIMEOUT_EN.
module biquad_coef_scheduler
    import eq_pkg::*;
#(
    parameter  int NUM_BIQUADS    = 8,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int IDX_W          = $clog2(NUM_BIQUADS)
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     enable,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_index,
    input  logic [2:0]               wr_sel,
    input  logic signed [COEF_W-1:0] wr_data,
    input  logic [NUM_BIQUADS-1:0]   commit,
    input  logic                     coefficients_updated,
    input  logic                     error_clr,
    output logic                     load_coefficients,
    output logic [IDX_W-1:0]         biquad_index,
    output logic signed [COEF_W-1:0] b0,
    output logic signed [COEF_W-1:0] b1,
    output logic signed [COEF_W-1:0] b2,
    output logic signed [COEF_W-1:0] a1,
    output logic signed [COEF_W-1:0] a2,
    output logic [NUM_BIQUADS-1:0]   pending,
    output logic                     busy,
    output logic                     load_error,
    output sched_state_t             state
);

    localparam logic [IDX_W:0] NUM_BANDS = (IDX_W+1)'(NUM_BIQUADS);

    coef_set_t              staging [NUM_BIQUADS];
    coef_set_t              coef_q;
    logic [IDX_W-1:0]       last;
    sched_state_t           state_d;
    logic                   grant_valid;
    logic [IDX_W-1:0]       grant_idx;
    logic                   start;
    logic                   ack;
    logic                   timeout;
    logic                   timeout_hit;
    logic                   wr_ok;
    logic [NUM_BIQUADS-1:0] clear_mask;

    eq_rr_picker #(.NUM_BIQUADS(NUM_BIQUADS)) u_picker (
        .req         (pending),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Handshake: load_coefficients rises with a stable index/coefficient set and
    // holds until coefficients_updated is seen high; the done level must then fall
    // before another request can start, so one long done pulse acknowledges once.
    always_comb begin
        state_d = state;
        start   = 1'b0;
        ack     = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                if (enable && grant_valid) begin
                    start   = 1'b1;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (coefficients_updated) begin
                    ack     = 1'b1;
                    state_d = RELEASE;
                end else if (timeout_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            RELEASE: begin
                if (!coefficients_updated) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    assign wr_ok      = wr_en && ({1'b0, wr_index} < NUM_BANDS);
    assign clear_mask = ack ? (NUM_BIQUADS'(1) << biquad_index) : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_BIQUADS; i++) begin
                staging[i]    <= '0;
                staging[i].b0 <= COEF_ONE;
            end
        end else if (wr_ok) begin
            case (wr_sel)
                SEL_B0:  staging[wr_index].b0 <= wr_data;
                SEL_B1:  staging[wr_index].b1 <= wr_data;
                SEL_B2:  staging[wr_index].b2 <= wr_data;
                SEL_A1:  staging[wr_index].a1 <= wr_data;
                SEL_A2:  staging[wr_index].a2 <= wr_data;
                default: ;
            endcase
        end
    end

    // A commit landing in the acknowledge cycle re-arms the band with newer values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending           <= '1;
            last              <= IDX_W'(NUM_BIQUADS - 1);
            load_coefficients <= 1'b0;
            biquad_index      <= '0;
            coef_q            <= '0;
        end else begin
            pending <= (pending & ~clear_mask) | commit;
            if (ack || timeout) begin
                last <= biquad_index;
            end
            if (start) begin
                load_coefficients <= 1'b1;
                biquad_index      <= grant_idx;
                coef_q            <= staging[grant_idx];
            end else if (ack || timeout) begin
                load_coefficients <= 1'b0;
            end
        end
    end

`ifdef EQ_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tmo_cnt <= '0;
        end else if (state != REQUEST || state_d != REQUEST) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            load_error <= 1'b0;
        end else if (timeout) begin
            load_error <= 1'b1;
        end else if (error_clr) begin
            load_error <= 1'b0;
        end
    end
`else
    logic unused_error_clr;

    assign unused_error_clr = error_clr;
    assign timeout_hit      = 1'b0;
    assign load_error       = 1'b0;
`endif

    assign busy = (state != IDLE);
    assign b0   = coef_q.b0;
    assign b1   = coef_q.b1;
    assign b2   = coef_q.b2;
    assign a1   = coef_q.a1;
    assign a2   = coef_q.a2;

endmodule

// File: tb/tb_biquad_coef_scheduler.sv
// Self-checking bench for biquad_coef_scheduler against a band-level reference model.
module tb_biquad_coef_scheduler;

    localparam int NB = 8;

    logic                Clk;
    logic                Reset_n;
    logic                enable;
    logic                wr_en;
    logic [2:0]          wr_index;
    logic [2:0]          wr_sel;
    logic signed [17:0]  wr_data;
    logic [NB-1:0]       commit;
    logic                coefficients_updated;
    logic                error_clr;
    logic                load_coefficients;
    logic [2:0]          biquad_index;
    logic signed [17:0]  b0, b1, b2, a1, a2;
    logic [NB-1:0]       pending;
    logic                busy;
    logic                load_error;
    eq_pkg::sched_state_t state;

    int checks = 0;
    int errors = 0;

    // Reference model: staged values per band, dirty set and last-served band.
    logic signed [17:0] m_stage [NB][5];
    logic [NB-1:0]      m_pending;
    int                 m_last;

    biquad_coef_scheduler dut (
        .Clk                  (Clk),
        .Reset_n              (Reset_n),
        .enable               (enable),
        .wr_en                (wr_en),
        .wr_index             (wr_index),
        .wr_sel               (wr_sel),
        .wr_data              (wr_data),
        .commit               (commit),
        .coefficients_updated (coefficients_updated),
        .error_clr            (error_clr),
        .load_coefficients    (load_coefficients),
        .biquad_index         (biquad_index),
        .b0                   (b0),
        .b1                   (b1),
        .b2                   (b2),
        .a1                   (a1),
        .a2                   (a2),
        .pending              (pending),
        .busy                 (busy),
        .load_error           (load_error),
        .state                (state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            m_stage[b][0] = 18'h10000;
            for (int s = 1; s < 5; s++) m_stage[b][s] = '0;
        end
        m_pending = '1;
        m_last    = NB - 1;
    endfunction

    function automatic int predict();
        for (int i = 1; i <= NB; i++) begin
            if (m_pending[(m_last + i) % NB]) return (m_last + i) % NB;
        end
        return -1;
    endfunction

    function automatic logic [92:0] expect_word(input int idx);
        logic [92:0] w;
        w = {3'(idx), m_stage[idx][0], m_stage[idx][1], m_stage[idx][2],
             m_stage[idx][3], m_stage[idx][4]};
        return w;
    endfunction

    task automatic drive_write(input int idx, input int sel, input logic signed [17:0] data,
                               input logic [NB-1:0] cmask);
        @(negedge Clk);
        wr_en    = 1'b1;
        wr_index = 3'(idx);
        wr_sel   = 3'(sel);
        wr_data  = data;
        commit   = cmask;
        @(negedge Clk);
        wr_en  = 1'b0;
        commit = '0;
        if (sel < 5) m_stage[idx][sel] = data;
        m_pending = m_pending | cmask;
    endtask

    task automatic drive_commit(input logic [NB-1:0] cmask);
        @(negedge Clk);
        commit = cmask;
        @(negedge Clk);
        commit    = '0;
        m_pending = m_pending | cmask;
    endtask

    task automatic wait_request(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clk);
            if (load_coefficients === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack_request(input int delay, input int hold, input logic [NB-1:0] cmask,
                               input int idx);
        repeat (delay) @(negedge Clk);
        coefficients_updated = 1'b1;
        commit               = cmask;
        @(negedge Clk);
        commit    = '0;
        m_pending = (m_pending & ~(NB'(1) << idx)) | cmask;
        m_last    = idx;
        repeat (hold - 1) @(negedge Clk);
        coefficients_updated = 1'b0;
    endtask

    task automatic test_reset();
        logic [92:0] got;
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        model_reset();
        got = {biquad_index, b0, b1, b2, a1, a2};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        checks++;
        if ({load_coefficients, busy, load_error, pending} !== {3'b000, 8'hff}) begin
            errors++;
            $display("FAIL reset_flags: load=%b busy=%b err=%b pending=%h expected 0 0 0 ff",
                     load_coefficients, busy, load_error, pending);
        end
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if (state !== eq_pkg::IDLE || load_coefficients !== 1'b0 || pending !== 8'hff) begin
            errors++;
            $display("FAIL reset_disabled_idle: state=%0d load=%b pending=%h", state,
                     load_coefficients, pending);
        end
    endtask

    task automatic serve_all(input string tag, input bit rand_ack);
        bit ok;
        int exp_i;
        logic [92:0] got;
        for (int n = 0; n < NB + 1 && m_pending != 0; n++) begin
            exp_i = predict();
            wait_request(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s_request: no request seen, expected band %0d", tag, exp_i);
                return;
            end
            got = {biquad_index, b0, b1, b2, a1, a2};
            checks++;
            if (got !== expect_word(exp_i)) begin
                errors++;
                $display("FAIL %s_load: got %h expected %h", tag, got, expect_word(exp_i));
            end
            if (rand_ack) ack_request($urandom_range(0, 3), $urandom_range(1, 3), '0, exp_i);
            else          ack_request(2, 1, '0, exp_i);
        end
        repeat (2) @(negedge Clk);
        checks++;
        if (pending !== 8'h00 || busy !== 1'b0 || m_pending !== 8'h00) begin
            errors++;
            $display("FAIL %s_drain: pending=%h busy=%b expected 00 0", tag, pending, busy);
        end
    endtask

    task automatic test_reset_sweep();
        @(negedge Clk);
        enable = 1'b1;
        serve_all("sweep", 1'b0);
    endtask

    task automatic test_single_band();
        bit ok;
        logic [92:0] got;
        drive_write(3, 0, 18'h08000, '0);
        drive_write(3, 3, 18'sh3C000, 8'h08);
        wait_request(ok);
        got = {biquad_index, b0, b1, b2, a1, a2};
        checks++;
        if (!ok || got !== {3'd3, 18'h08000, 18'h0, 18'h0, 18'h3C000, 18'h0}) begin
            errors++;
            $display("FAIL single_band: req=%b got %h", ok, got);
        end
        ack_request(2, 1, '0, 3);
        repeat (2) @(negedge Clk);
        checks++;
        if (busy !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL single_band_done: busy=%b pending=%h expected 0 00", busy, pending);
        end
    endtask

    task automatic test_commit_race();
        bit ok;
        drive_commit(8'h08);
        wait_request(ok);
        ack_request(1, 1, 8'h08, 3);
        checks++;
        if (pending !== m_pending) begin
            errors++;
            $display("FAIL commit_race_pending: got %h expected %h", pending, m_pending);
        end
        wait_request(ok);
        checks++;
        if (!ok || biquad_index !== 3'd3) begin
            errors++;
            $display("FAIL commit_race_rerequest: req=%b index %0d expected 3", ok, biquad_index);
        end
        ack_request(1, 1, '0, 3);
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_long_ack();
        bit ok;
        int exp_i;
        drive_commit(8'h22);
        exp_i = predict();
        wait_request(ok);
        checks++;
        if (!ok || biquad_index !== 3'(exp_i)) begin
            errors++;
            $display("FAIL long_ack_first: req=%b index %0d expected %0d", ok, biquad_index, exp_i);
        end
        coefficients_updated = 1'b1;
        @(negedge Clk);
        m_pending = m_pending & ~(NB'(1) << exp_i);
        m_last    = exp_i;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checks++;
            if (load_coefficients !== 1'b0 || pending !== m_pending) begin
                errors++;
                $display("FAIL long_ack_hold: load=%b pending=%h expected 0 %h",
                         load_coefficients, pending, m_pending);
            end
        end
        coefficients_updated = 1'b0;
        exp_i = predict();
        wait_request(ok);
        checks++;
        if (!ok || biquad_index !== 3'(exp_i)) begin
            errors++;
            $display("FAIL long_ack_next: req=%b index %0d expected %0d", ok, biquad_index, exp_i);
        end
        ack_request(1, 1, '0, exp_i);
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_inflight_write();
        bit ok;
        logic [92:0] snap, got;
        drive_write(6, 1, 18'($urandom), 8'h40);
        snap = expect_word(6);
        wait_request(ok);
        drive_write(6, 1, 18'($urandom), '0);
        drive_write(6, 4, 18'($urandom), '0);
        got = {biquad_index, b0, b1, b2, a1, a2};
        checks++;
        if (!ok || got !== snap) begin
            errors++;
            $display("FAIL inflight_hold: req=%b got %h expected %h", ok, got, snap);
        end
        ack_request(1, 1, '0, 6);
        drive_commit(8'h40);
        wait_request(ok);
        got = {biquad_index, b0, b1, b2, a1, a2};
        checks++;
        if (!ok || got !== expect_word(6)) begin
            errors++;
            $display("FAIL inflight_newer: got %h expected %h", got, expect_word(6));
        end
        ack_request(1, 1, '0, 6);
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_enable_low();
        bit ok;
        bit seen;
        drive_commit(8'h04);
        wait_request(ok);
        enable = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (!ok || load_coefficients !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL enable_low_hold: load=%b busy=%b expected 1 1", load_coefficients, busy);
        end
        ack_request(0, 1, '0, 2);
        drive_commit(8'h10);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (load_coefficients !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || pending !== m_pending) begin
            errors++;
            $display("FAIL enable_low_idle: started=%b pending=%h expected 0 %h", seen, pending,
                     m_pending);
        end
        enable = 1'b1;
        serve_all("enable_resume", 1'b0);
    endtask

    task automatic test_random();
        int idx;
        for (int r = 0; r < 4; r++) begin
            @(negedge Clk);
            enable = 1'b0;
            for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
                idx = $urandom_range(0, NB - 1);
                drive_write(idx, $urandom_range(0, 7), 18'($urandom),
                            ($urandom_range(0, 1) == 1) ? (NB'(1) << idx) : '0);
            end
            drive_commit(NB'($urandom_range(1, 255)));
            enable = 1'b1;
            serve_all("random", 1'b1);
        end
    endtask

    task automatic test_reset_midrequest();
        bit ok;
        drive_commit(8'h20);
        wait_request(ok);
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (!ok || load_coefficients !== 1'b0 || busy !== 1'b0 || pending !== 8'hff ||
            {biquad_index, b0, b1, b2, a1, a2} !== '0) begin
            errors++;
            $display("FAIL reset_midrequest: req=%b load=%b busy=%b pending=%h b0=%h", ok,
                     load_coefficients, busy, pending, b0);
        end
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        serve_all("post_reset", 1'b1);
    endtask

`ifdef EQ_LOAD_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int cnt;
        drive_commit(8'h04);
        wait_request(ok);
        enable = 1'b0;
        cnt    = 1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge Clk);
            if (load_coefficients !== 1'b1) break;
            cnt++;
        end
        m_last = 2;
        checks++;
        if (!ok || cnt != 4096) begin
            errors++;
            $display("FAIL timeout_length: high for %0d cycles expected 4096", cnt);
        end
        checks++;
        if (load_error !== 1'b1 || pending !== m_pending || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: err=%b pending=%h busy=%b expected 1 %h 0", load_error,
                     pending, busy, m_pending);
        end
        error_clr = 1'b1;
        @(negedge Clk);
        error_clr = 1'b0;
        checks++;
        if (load_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: err=%b expected 0", load_error);
        end
        enable = 1'b1;
        serve_all("timeout_retry", 1'b0);
    endtask
`endif

    initial begin
        Reset_n              = 1'b0;
        enable               = 1'b0;
        wr_en                = 1'b0;
        wr_index             = '0;
        wr_sel               = '0;
        wr_data              = '0;
        commit               = '0;
        coefficients_updated = 1'b0;
        error_clr            = 1'b0;
        model_reset();
        test_reset();
        test_reset_sweep();
        test_single_band();
        test_commit_race();
        test_long_ack();
        test_inflight_write();
        test_enable_low();
        test_random();
        test_reset_midrequest();
`ifdef EQ_LOAD_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/biquad_coef_scheduler.md
# biquad_coef_scheduler

Keeps a staging bank of five 18-bit coefficients for each of NUM_BIQUADS equalizer bands. Host logic (switch/NIOS register front end) writes coefficients and commits bands atomically. The scheduler then feeds committed bands one at a time into `audio_controller` through its `load_coefficients` / `coefficients_updated` handshake, choosing among pending bands round-robin. It sits between the control-register front end and `audio_controller`, and drives that block's `load_coefficients`, `biquad_index` and `b0`..`a2` inputs.

## Interface
- NUM_BIQUADS, 8, number of bands; index width IDX_W = $clog2(NUM_BIQUADS), 3 at default
- TIMEOUT_CYCLES, 4096, handshake watchdog limit (used only with EQ_LOAD_TIMEOUT_EN)
- Clk  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = may start new transactions; 0 = finish the current one, start none
- wr_en  in  1  write `wr_data` into staging[wr_index][wr_sel]
- wr_index  in  IDX_W  band select; writes with wr_index ≥ NUM_BIQUADS are ignored
- wr_sel  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; values 5..7 are ignored
- wr_data  in  18 signed  coefficient, Q2.16
- commit  in  NUM_BIQUADS  one-cycle strobes; bit k marks band k pending
- coefficients_updated  in  1  done indication from `audio_controller`; may stay high several cycles
- error_clr  in  1  clears `load_error`
- load_coefficients  out  1  request to `audio_controller`, registered
- biquad_index  out  IDX_W  band being loaded, registered
- b0, b1, b2, a1, a2  out  18 signed  latched coefficient set, registered
- pending  out  NUM_BIQUADS  per-band dirty bits
- busy  out  1  1 when state ≠ IDLE
- load_error  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, REQUEST, RELEASE.
- IDLE:
  - If `enable` and `pending` ≠ 0, the round-robin picker selects the first pending band at or after `last+1`, wrapping modulo NUM_BIQUADS.
  - The selected band's five staging values, and its index, are copied into the output registers.
  - Next state is REQUEST.
- REQUEST:
  - `load_coefficients` = 1, and outputs are held stable.
  - On `coefficients_updated` = 1:
    - clear that band's pending bit;
    - set `last` to that index;
    - `load_coefficients` goes to 0 on the next cycle;
    - next state is RELEASE.
- RELEASE: wait for `coefficients_updated` = 0, then go to IDLE. This prevents a long done level from being counted twice.
- Writes and commits are accepted in every state. The outputs are a latched copy, so staging writes never disturb an in-flight load.
- If `commit[k]` arrives in the same cycle that pending[k] is being cleared, the commit wins and the bit stays 1, so the band is reloaded with the newer values.
- Simultaneous `wr_en` and `commit` on the same band: the write lands first and is included in that commit.
- Deasserting `enable` does not abort a REQUEST in progress.

## Timing
- Reset values:
  - staging b0 = 18'h10000 (1.0); all other coefficients 0 (unity pass-through)
  - `pending` = all ones, so every band is pushed after reset
  - `last` = NUM_BIQUADS−1, so band 0 is loaded first
  - `load_coefficients` = 0, `biquad_index` = 0, coefficient outputs = 0
  - `busy` = 0, `load_error` = 0, state = IDLE
- IDLE decision at edge t: `load_coefficients` is high from t+1.
- `coefficients_updated` seen high at edge t: `load_coefficients` is low and the pending bit is clear from t+1.
- Minimum spacing between consecutive requests: 3 cycles (REQUEST → RELEASE → IDLE → REQUEST).
- Asserting `Reset_n` low at any point, including mid-REQUEST, immediately returns every register to its reset value.

## Configuration
- EQ_LOAD_TIMEOUT_EN defined:
  - A counter runs while in REQUEST.
  - If it reaches TIMEOUT_CYCLES without `coefficients_updated`, then:
    - `load_coefficients` drops;
    - the pending bit is kept;
    - `load_error` is set;
    - next state is IDLE;
    - `last` advances, so other bands are not starved.
  - `load_error` is cleared only by `error_clr` or reset.
- EQ_LOAD_TIMEOUT_EN undefined:
  - REQUEST waits indefinitely.
  - `load_error` is tied 0, `error_clr` is ignored, and no counter is synthesized.

## Structure
- Package `eq_pkg`:
  - COEF_W = 18
  - COEF_ONE = 18'h10000
  - `coef_set_t` packed struct {b0, b1, b2, a1, a2}
  - `sched_state_t` enum
  - coefficient select constants SEL_B0..SEL_A2
- Sub-module `eq_rr_picker`: combinational round-robin picker. Inputs are `req` vector and `last`; outputs are `grant_valid` and `grant_idx`.

## Test plan
- Reset, `enable` = 1, `coefficients_updated` pulsed 2 cycles after each request → bands load in order 0..7, each with b0 = 0x10000 and the rest 0; `pending` reaches 0.
- Write band 3 with b0 = 0x08000 and a1 = 0x3C000, commit bit 3 → a single request with index 3 and exactly those values; `busy` returns to 0.
- `commit[3]` in the same cycle `coefficients_updated` acknowledges band 3 → pending[3] stays 1 and band 3 is requested again.
- `coefficients_updated` held high for 5 cycles → exactly one pending bit is cleared and the next request starts only after it falls.
- Staging write to the in-flight band during REQUEST → output coefficients unchanged until the transaction completes.
- With EQ_LOAD_TIMEOUT_EN, never acknowledge → `load_coefficients` drops after 4096 cycles, `load_error` = 1, the band stays pending; `error_clr` clears the flag.
